// File: rtl/mem_dump_reader_if.sv
// rtl/mem_dump_reader_if.sv - memory read port and byte stream bundle for the dump reader
interface mem_dump_reader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_select;
  logic [31:0]           mem_data;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    output mem_address, mem_select, tx_data, tx_valid,
    input  mem_data, tx_ready
  );

  modport slave (
    input  mem_address, mem_select, tx_data, tx_valid,
    output mem_data, tx_ready
  );
endinterface

// File: rtl/mem_dump_reader.sv
// rtl/mem_dump_reader.sv - halted-core data memory read-out, streamed as bytes MSB first
module mem_dump_reader #(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_address,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  busy,
  output logic                  done,
  mem_dump_reader_if.master     bus
);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, LOAD, SEND, DONE} state_t;

  localparam logic [1:0] LAT_LAST = (READ_LATENCY >= 2) ? 2'(READ_LATENCY - 2) : 2'd0;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic [31:0]           shift_q;
  logic [1:0]            byte_idx;
  logic [1:0]            lat_q;
  logic                  tx_valid_q;
  logic                  busy_q;
  logic                  done_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      shift_q     <= '0;
      byte_idx    <= '0;
      lat_q       <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr_q      <= start_address;
            remaining_q <= word_count;
            busy_q      <= 1'b1;
            if (word_count == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= ADDR;
            end
          end
        end
        ADDR: begin
          lat_q <= '0;
          state <= (READ_LATENCY > 1) ? WAIT : LOAD;
        end
        WAIT: begin
          if (lat_q == LAT_LAST) state <= LOAD;
          else                   lat_q <= lat_q + 2'd1;
        end
        LOAD: begin
          shift_q    <= bus.mem_data;
          byte_idx   <= '0;
          tx_valid_q <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          // Output only advances on a handshake, so a stalled byte stays stable.
          if (bus.tx_ready) begin
            shift_q  <= {shift_q[23:0], 8'h00};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              tx_valid_q  <= 1'b0;
              remaining_q <= remaining_q - CNT_ONE;
              addr_q      <= addr_q + ADDR_ONE;
              if (remaining_q > CNT_ONE) begin
                state <= ADDR;
              end else begin
                state  <= DONE;
                done_q <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_address = addr_q;
  assign bus.mem_select  = busy_q;
  assign bus.tx_data     = shift_q[31:24];
  assign bus.tx_valid    = tx_valid_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
// tb/tb_mem_dump_reader.sv - bench for mem_dump_reader against an address-range byte model
module tb_mem_dump_reader;
  localparam int AW    = 10;
  localparam int RL    = 1;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_address = '0;
  logic [AW:0]   word_count = '0;
  logic          busy;
  logic          done;

  mem_dump_reader_if #(.ADDR_WIDTH(AW)) bus ();

  mem_dump_reader #(.READ_LATENCY(RL), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .start_address(start_address),
    .word_count(word_count), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory with READ_LATENCY register stages on the read path.
  logic [31:0] mem [DEPTH];
  logic [31:0] rd_pipe [RL];
  always @(posedge clock) begin
    rd_pipe[0] <= mem[bus.mem_address];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_data = rd_pipe[RL-1];

  bit rand_ready = 1'b0;
  bit ready_fixed = 1'b1;
  int stall_left = 0;
  always @(posedge clock) begin
    #1;
    if (!rand_ready) bus.tx_ready = ready_fixed;
    else if (stall_left > 0) begin
      bus.tx_ready = 1'b0;
      stall_left--;
    end else if ($urandom_range(0, 2) == 0) begin
      bus.tx_ready = 1'b0;
      stall_left = $urandom_range(0, 4);
    end else bus.tx_ready = 1'b1;
  end

  logic [7:0] got[$];
  logic [7:0] exp[$];
  int         stable_errs = 0;
  bit         stall_q = 1'b0;
  logic [7:0] stall_data = '0;
  always @(negedge clock) begin
    if (!reset_n) stall_q = 1'b0;
    else begin
      if (stall_q && (bus.tx_valid !== 1'b1 || bus.tx_data !== stall_data)) stable_errs++;
      stall_q = bus.tx_valid && !bus.tx_ready;
      stall_data = bus.tx_data;
      if (bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
    end
  end

  task automatic build_expected(input int a, input int n);
    exp.delete();
    for (int w = 0; w < n; w++) begin
      logic [31:0] word;
      word = mem[(a + w) % DEPTH];
      for (int b = 3; b >= 0; b--) exp.push_back(word[8*b +: 8]);
    end
  endtask

  task automatic pulse_start(input int a, input int n);
    @(posedge clock); #1;
    start = 1'b1;
    start_address = a[AW-1:0];
    word_count = n[AW:0];
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clock);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %b want 0", bus.tx_valid); end
    n_checks++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    n_checks++; if (bus.mem_select !== 1'b0 || bus.mem_address !== '0) begin n_fail++; $display("FAIL reset_mem got sel %b addr %0d want 0 0", bus.mem_select, bus.mem_address); end
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_single_word();
    int first_valid = -1, done_at = -1, done_pulses = 0, busy_cycles = 0, valid_cycles = 0;
    mem[5] = 32'h12345678;
    rand_ready = 1'b0; ready_fixed = 1'b1;
    got.delete(); stable_errs = 0;
    build_expected(5, 1);
    pulse_start(5, 1);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (k == 1) begin
        n_checks++; if (bus.mem_select !== 1'b1 || bus.mem_address !== 10'd5) begin n_fail++; $display("FAIL single_addr got sel %b addr %0d want 1 5", bus.mem_select, bus.mem_address); end
      end
      if (bus.tx_valid === 1'b1) begin
        valid_cycles++;
        if (first_valid < 0) first_valid = k;
      end
      if (done === 1'b1) begin done_pulses++; if (done_at < 0) done_at = k; end
      if (busy === 1'b1) busy_cycles++;
    end
    n_checks++; if (first_valid !== 3) begin n_fail++; $display("FAIL single_first_valid got %0d want 3", first_valid); end
    n_checks++; if (valid_cycles !== 4) begin n_fail++; $display("FAIL single_valid_cycles got %0d want 4", valid_cycles); end
    n_checks++; if (done_at !== 7 || done_pulses !== 1) begin n_fail++; $display("FAIL single_done got at %0d pulses %0d want 7 1", done_at, done_pulses); end
    n_checks++; if (busy_cycles !== 7) begin n_fail++; $display("FAIL single_busy got %0d want 7", busy_cycles); end
    n_checks++; if (bus.mem_select !== 1'b0) begin n_fail++; $display("FAIL single_sel_after got %b want 0", bus.mem_select); end
    n_checks++; if (got.size() !== exp.size()) begin n_fail++; $display("FAIL single_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL single_byte%0d got %h want %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_dump(input string name, input int a, input int n);
    bit ok;
    rand_ready = 1'b1;
    got.delete(); stable_errs = 0;
    build_expected(a, n);
    pulse_start(a, n);
    wait_done(400 * (n + 1), ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL %s_timeout got no done want done", name); end
    repeat (2) @(negedge clock);
    rand_ready = 1'b0; ready_fixed = 1'b1;
    n_checks++; if (got.size() !== exp.size()) begin n_fail++; $display("FAIL %s_count got %0d want %0d", name, got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL %s_byte%0d got %h want %h", name, i, got[i], exp[i]); end
    end
    n_checks++; if (stable_errs !== 0) begin n_fail++; $display("FAIL %s_stall_stable got %0d want 0", name, stable_errs); end
  endtask

  task automatic test_zero_count();
    int done_at = -1, busy_cycles = 0, valid_cycles = 0;
    rand_ready = 1'b0; ready_fixed = 1'b1;
    pulse_start(77, 0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (done === 1'b1 && done_at < 0) done_at = k;
      if (busy === 1'b1) busy_cycles++;
      if (bus.tx_valid === 1'b1) valid_cycles++;
    end
    n_checks++; if (done_at !== 1) begin n_fail++; $display("FAIL zero_done got %0d want 1", done_at); end
    n_checks++; if (busy_cycles !== 1) begin n_fail++; $display("FAIL zero_busy got %0d want 1", busy_cycles); end
    n_checks++; if (valid_cycles !== 0) begin n_fail++; $display("FAIL zero_valid got %0d want 0", valid_cycles); end
  endtask

  task automatic test_restart_ignored();
    bit ok, seen;
    int a;
    a = $urandom_range(0, DEPTH - 1);
    rand_ready = 1'b1;
    got.delete(); stable_errs = 0;
    build_expected(a, 3);
    pulse_start(a, 3);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clock);
      if (bus.tx_valid === 1'b1) seen = 1'b1;
    end
    pulse_start((a + 100) % DEPTH, 5);
    wait_done(2000, ok);
    n_checks++; if (ok !== 1'b1 || seen !== 1'b1) begin n_fail++; $display("FAIL restart_timeout got done %b valid %b want 1 1", ok, seen); end
    repeat (3) @(negedge clock);
    rand_ready = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_busy_after got %b want 0", busy); end
    n_checks++; if (got.size() !== exp.size()) begin n_fail++; $display("FAIL restart_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      n_checks++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL restart_byte%0d got %h want %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid_dump();
    int nvalid = 0;
    bit hit = 1'b0;
    rand_ready = 1'b0; ready_fixed = 1'b1;
    pulse_start($urandom_range(0, DEPTH - 1), 2);
    for (int k = 0; k < 50 && !hit; k++) begin
      @(negedge clock);
      if (bus.tx_valid === 1'b1) nvalid++;
      if (nvalid == 3) hit = 1'b1;
    end
    #1 reset_n = 1'b0;
    @(negedge clock);
    n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL midreset_reach got %b want 1", hit); end
    n_checks++; if (bus.tx_valid !== 1'b0 || busy !== 1'b0 || bus.mem_select !== 1'b0) begin n_fail++; $display("FAIL midreset_outputs got v%b b%b s%b want 000", bus.tx_valid, busy, bus.mem_select); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    test_dump("after_reset", $urandom_range(0, DEPTH - 1), 3);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    test_reset();
    test_single_word();
    test_dump("backpressure", $urandom_range(0, DEPTH - 1), 2);
    test_dump("wrap", 1022, 4);
    test_zero_count();
    test_restart_ignored();
    test_reset_mid_dump();
    for (int r = 0; r < 4; r++) test_dump("random", $urandom_range(0, DEPTH - 1), $urandom_range(1, 6));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_dump_reader.md
# mem_dump_reader

Debug read-out engine for the data memory of the pipelined MIPS-DLX core. While the core is halted, it takes over the memory's address port, reads a contiguous range of 32-bit words, and streams them as bytes, MSB first, over a valid/ready byte interface toward the UART transmitter. It is the read-side counterpart of the memory stage's store path and never writes memory.

## Interface
- READ_LATENCY, 1: cycles from address presented to `mem_data` valid (1..3).
- ADDR_WIDTH, 10: word-address width of data memory.
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous reset, active low.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- start_address  in  ADDR_WIDTH  first word address; latched on accepted start.
- word_count  in  ADDR_WIDTH+1  number of words to dump (0..1024); latched on accepted start.
- mem_address  out  ADDR_WIDTH  address driven to the memory read port.
- mem_select  out  1  high while this block owns the memory address mux; memory write enable must be forced 0 when high.
- mem_data  in  32  memory read data.
- tx_data  out  8  byte to transmitter.
- tx_valid  out  1  byte available.
- tx_ready  in  1  transmitter accepts byte when `tx_valid && tx_ready`.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a dump completes.

## Operation
- States: IDLE, ADDR, WAIT, LOAD, SEND, DONE.
- IDLE: `start` high latches `start_address` into `addr_q` and `word_count` into `remaining_q`. If `word_count` is 0, go to DONE; otherwise go to ADDR. Ignore `start` in all other states.
- ADDR: drive `mem_address = addr_q`. Go to WAIT if READ_LATENCY > 1, else go to LOAD.
- WAIT: stay for READ_LATENCY-1 cycles using a latency counter, holding `mem_address`, then go to LOAD.
- LOAD: capture `mem_data` into a 32-bit shift register, clear `byte_idx` to 0, and go to SEND.
- SEND: `tx_valid = 1` and `tx_data = shift[31:24]`. On each handshake, shift left by 8 and increment `byte_idx`. After the 4th handshake, decrement `remaining_q` and increment `addr_q` modulo 2^ADDR_WIDTH (1023 wraps to 0). Then go to ADDR if `remaining_q` was greater than 1, else go to DONE.
- DONE: `done = 1` for one cycle, then go to IDLE.
- `mem_select` equals `busy`. `mem_address` holds `addr_q` in every state.
- Byte order per word is [31:24], [23:16], [15:8], [7:0].
- Word order is ascending address with wrap-around. A count of 1024 dumps the whole memory exactly once.

## Timing
- Reset values: state IDLE; `tx_valid` 0, `tx_data` 0, `busy` 0, `done` 0, `mem_select` 0, `mem_address` 0; internal counters 0.
- Reset asserted mid-dump returns to IDLE on that edge. `tx_valid` drops the same cycle with no partial-word completion. Memory is never written.
- With READ_LATENCY=1, if `start` is sampled at edge N:
  - state ADDR from edge N, with the address on `mem_address` during cycle N+1;
  - LOAD in cycle N+2;
  - `tx_valid` high from cycle N+3.
- With READ_LATENCY=L, the first `tx_valid` arrives L+2 cycles after start.
- Per-word overhead between the last byte handshake and the next `tx_valid` is READ_LATENCY+1 cycles.
- Handshake: once `tx_valid` rises, `tx_valid` and `tx_data` stay stable until `tx_ready` is sampled high. `tx_valid` never drops without a handshake except on reset.
- `tx_ready` high while `tx_valid` is low has no effect.
- With `tx_ready` tied high, one byte transfers per cycle within a word.
- `done` is asserted the cycle after the final handshake. When `word_count` is 0, `done` is asserted the cycle after start.
- `busy` rises the cycle after an accepted start and falls the cycle after `done`.

## Test plan
- Dump 1 word at address 5, memory[5]=0x12345678, `tx_ready`=1 -> bytes 0x12, 0x34, 0x56, 0x78 on consecutive cycles; first `tx_valid` 3 cycles after start; one `done` pulse; `mem_select` low afterwards.
- Backpressure: dump 2 words, `tx_ready` toggled randomly with stalls up to 5 cycles -> exactly 8 bytes in order; `tx_data` never changes while `tx_valid && !tx_ready`.
- Wrap: `start_address`=1022, `word_count`=4 -> words read from addresses 1022, 1023, 0, 1; 16 bytes transferred.
- `word_count`=0 -> no `tx_valid`; `done` 1 cycle after start; `busy` high for exactly 1 cycle.
- `start` pulsed again during SEND with different arguments -> ignored; the original range completes unchanged.
- `reset_n` low during the 3rd byte of word 0 -> next cycle `tx_valid`=0, `busy`=0, `mem_select`=0. A new start then dumps correctly from the new arguments.
